shift_ext_unit: RTL and testbench
=================================

// Module: shift_ext_unit
// PURPOSE
// - Parametrised, multi-cycle shift/extend unit for the stage-4 datapath of the JALA stack CPU.
// - Replaces the combinational shifter and immediate extenders with a Start/Busy/Done handshake driven by Control.
// - Latches operands on Start and shifts up to STEP bits per cycle.
// - Also latches the zero- and sign-extended IR immediate.
// PARAMETERS
// - WIDTH      16  data width of ShifterIn/ShifterOut/extender outputs
// - IMM_WIDTH  12  width of IR immediate field (IMM_WIDTH < WIDTH)
// - STEP        4  max shift bits applied per SHIFT cycle (1..WIDTH)
// PORTS
// - CLK         in   1          clock; all state updates on rising edge
// - Rst         in   1          synchronous, active-high reset
// - Start       in   1          request; accepted only in IDLE
// - ShifterIn   in   WIDTH      operand to shift
// - IRImm       in   IMM_WIDTH  IR immediate field (IR[11:0])
// - AmtReg      in   WIDTH      register-sourced shift amount
// - AmtSel      in   1          0: amount = zero-extended IRImm, 1: amount = AmtReg
// - Mode        in   2          00 logical, 01 arithmetic, 10 rotate (ROTATE_EN only), 11 logical
// - Dir         in   1          0 left, 1 right
// - Busy        out  1          high in SHIFT and DONE
// - Done        out  1          one-cycle pulse, result valid
// - ShifterOut  out  WIDTH      result register; held until next Done
// - ZeroExtOut  out  WIDTH      {0s, IRImm} latched at Start
// - SignExtOut  out  WIDTH      {IRImm[MSB] repeated, IRImm} latched at Start
// BEHAVIOUR
// - Reset: state=IDLE.
// - Reset: Busy=0, Done=0, ShifterOut=0, ZeroExtOut=0, SignExtOut=0; internal Acc/Rem cleared.
// - Reset wins over every other input.
// - Reset mid-operation aborts the operation: no Done pulse, and the partial result is discarded.
// - States: IDLE, SHIFT, DONE.
// - IDLE & Start: Acc<=ShifterIn; Rem<=effective amount; latch Mode/Dir/extends; ->SHIFT.
// - IDLE & !Start: hold all outputs.
// - Effective amount: non-rotate modes clamp to min(amt, WIDTH). Rem width is $clog2(WIDTH)+1.
// - SHIFT & Rem==0: ShifterOut<=Acc; ->DONE.
// - SHIFT & Rem!=0: s=min(Rem,STEP); Acc<=Acc shifted by s; Rem<=Rem-s; stay in SHIFT.
// - Logical: zero fill.
// - Arithmetic right: fill with Acc[WIDTH-1]. Arithmetic left is identical to logical left.
// - Amount >= WIDTH: logical gives 0; arithmetic right gives all sign bits.
// - DONE: Done=1 for exactly this cycle; ->IDLE unconditionally.
// - Latency: Done is high in cycle ceil(amt_eff/STEP)+2 after the Start sample edge.
// - Start asserted in SHIFT/DONE is ignored: no queueing, latched operands unaffected.
// - ShifterIn/IRImm/AmtReg changes after Start have no effect on the operation.
// CONFIGURATION
// - ROTATE_EN defined: Mode=10 rotates in direction Dir.
//   - Effective amount = amt mod WIDTH (no clamp).
//   - Bits shifted out re-enter at the opposite end.
// - ROTATE_EN undefined: Mode=10 behaves exactly as logical (00); no rotate logic synthesised.
// TESTING
// - ShifterIn=16'hF00F, IRImm=12'h004, AmtSel=0, Mode=00, Dir=1 -> ShifterOut=16'h0F00, Done 3 cycles after Start.
// - ShifterIn=16'h8000, IRImm=12'h00F, Mode=01, Dir=1 -> ShifterOut=16'hFFFF, Done at cycle 6.
// - AmtSel=1, AmtReg=20, Mode=00, Dir=0, ShifterIn=16'hFFFF -> 16'h0000 (clamped to 16), Done at cycle 6.
// - Same amount, Mode=01, Dir=1, ShifterIn=16'h8001 -> 16'hFFFF.
// - IRImm=12'h800, amt 0 -> ShifterOut=ShifterIn, Done at cycle 2, ZeroExtOut=16'h0800, SignExtOut=16'hF800.
// - Start while Busy: ignored; first result unchanged.
// - Rst pulsed during SHIFT -> next cycle Busy=0 and all outputs 0, and Done never pulses.
// - ROTATE_EN: Mode=10, Dir=0, ShifterIn=16'h8001, AmtReg=17 -> 16'h0003.
// - Without ROTATE_EN, the same stimulus -> 16'h0000.

Source files
------------

// File: rtl/shift_ext_unit.sv
// Multi-cycle shift/extend unit with a Start/Busy/Done handshake, shifting up to STEP bits a cycle.
// Define ROTATE_EN to make Mode=2'b10 a rotate; otherwise Mode=2'b10 is a logical shift.
module shift_ext_unit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned IMM_WIDTH = 12,
    parameter int unsigned STEP      = 4
) (
    input  logic                 CLK,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     ShifterIn,
    input  logic [IMM_WIDTH-1:0] IRImm,
    input  logic [WIDTH-1:0]     AmtReg,
    input  logic                 AmtSel,
    input  logic [1:0]           Mode,
    input  logic                 Dir,
    output logic                 Busy,
    output logic                 Done,
    output logic [WIDTH-1:0]     ShifterOut,
    output logic [WIDTH-1:0]     ZeroExtOut,
    output logic [WIDTH-1:0]     SignExtOut
);
    localparam int unsigned REM_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [REM_W-1:0] WIDTH_R = REM_W'(WIDTH);
    localparam logic [REM_W-1:0] STEP_R  = REM_W'(STEP);
    localparam logic [WIDTH-1:0] WIDTH_W = WIDTH'(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [REM_W-1:0] rem;
    logic             dirRight;
    logic             arith;

    logic [WIDTH-1:0] zeroExt;
    logic [WIDTH-1:0] signExt;
    logic [WIDTH-1:0] rawAmt;
    logic [REM_W-1:0] effAmt;
    logic [REM_W-1:0] stepAmt;
    logic [WIDTH-1:0] accShifted;

    assign zeroExt = {{(WIDTH - IMM_WIDTH){1'b0}}, IRImm};
    assign signExt = {{(WIDTH - IMM_WIDTH){IRImm[IMM_WIDTH-1]}}, IRImm};
    assign rawAmt  = AmtSel ? AmtReg : zeroExt;

`ifdef ROTATE_EN
    logic rotate;
    logic startRotate;

    assign startRotate = (Mode == 2'b10);

    // Rotates wrap the amount instead of clamping it.
    always_comb begin
        if (startRotate) begin
            effAmt = REM_W'(rawAmt % WIDTH_W);
        end else if (rawAmt >= WIDTH_W) begin
            effAmt = WIDTH_R;
        end else begin
            effAmt = rawAmt[REM_W-1:0];
        end
    end
`else
    always_comb begin
        if (rawAmt >= WIDTH_W) begin
            effAmt = WIDTH_R;
        end else begin
            effAmt = rawAmt[REM_W-1:0];
        end
    end
`endif

    assign stepAmt = (rem > STEP_R) ? STEP_R : rem;

    always_comb begin
        if (!dirRight) begin
            accShifted = acc << stepAmt;
        end else if (arith) begin
            accShifted = $signed(acc) >>> stepAmt;
        end else begin
            accShifted = acc >> stepAmt;
        end
`ifdef ROTATE_EN
        if (rotate) begin
            if (dirRight) begin
                accShifted = (acc >> stepAmt) | (acc << (WIDTH_R - stepAmt));
            end else begin
                accShifted = (acc << stepAmt) | (acc >> (WIDTH_R - stepAmt));
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state      <= IDLE;
            acc        <= '0;
            rem        <= '0;
            dirRight   <= 1'b0;
            arith      <= 1'b0;
            ShifterOut <= '0;
            ZeroExtOut <= '0;
            SignExtOut <= '0;
`ifdef ROTATE_EN
            rotate     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        acc        <= ShifterIn;
                        rem        <= effAmt;
                        dirRight   <= Dir;
                        arith      <= (Mode == 2'b01);
                        ZeroExtOut <= zeroExt;
                        SignExtOut <= signExt;
`ifdef ROTATE_EN
                        rotate     <= startRotate;
`endif
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rem == '0) begin
                        ShifterOut <= acc;
                        state      <= DONE;
                    end else begin
                        acc <= accShifted;
                        rem <= rem - stepAmt;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy = (state == SHIFT) || (state == DONE);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_shift_ext_unit.sv
// Self-checking bench for shift_ext_unit: directed spec cases plus randomized operations
// compared against an arithmetic reference model.
module tb_shift_ext_unit;
    logic        CLK;
    logic        Rst;
    logic        Start;
    logic [15:0] ShifterIn;
    logic [11:0] IRImm;
    logic [15:0] AmtReg;
    logic        AmtSel;
    logic [1:0]  Mode;
    logic        Dir;
    logic        Busy;
    logic        Done;
    logic [15:0] ShifterOut;
    logic [15:0] ZeroExtOut;
    logic [15:0] SignExtOut;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    shift_ext_unit #(
        .WIDTH    (16),
        .IMM_WIDTH(12),
        .STEP     (4)
    ) dut (
        .CLK       (CLK),
        .Rst       (Rst),
        .Start     (Start),
        .ShifterIn (ShifterIn),
        .IRImm     (IRImm),
        .AmtReg    (AmtReg),
        .AmtSel    (AmtSel),
        .Mode      (Mode),
        .Dir       (Dir),
        .Busy      (Busy),
        .Done      (Done),
        .ShifterOut(ShifterOut),
        .ZeroExtOut(ZeroExtOut),
        .SignExtOut(SignExtOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit isRot(input logic [1:0] mode);
        bit r;
        r = (mode == 2'b10);
`ifndef ROTATE_EN
        r = 1'b0;
`endif
        return r;
    endfunction

    // Whole-operation result, computed in one go from the amount.
    function automatic logic [15:0] refShift(input logic [15:0] x, input int amt,
                                             input logic [1:0] mode, input logic dir);
        logic [31:0] dbl;
        int a;
        if (isRot(mode)) begin
            a   = amt % 16;
            dbl = {x, x};
            if (dir) begin
                dbl = dbl >> a;
                return dbl[15:0];
            end
            dbl = dbl << a;
            return dbl[31:16];
        end
        if (amt >= 16) return (dir && mode == 2'b01) ? {16{x[15]}} : 16'h0000;
        if (!dir) return x << amt;
        if (mode == 2'b01) return $signed(x) >>> amt;
        return x >> amt;
    endfunction

    task automatic runOp(input string tag, input logic [15:0] x, input logic [11:0] imm,
                         input logic [15:0] amtR, input logic sel, input logic [1:0] mode,
                         input logic dir, input bit poke, output logic [15:0] result);
        int amt;
        int eff;
        int expEdges;
        int edges;
        logic [15:0] expOut;
        amt      = sel ? int'(amtR) : int'(imm);
        eff      = isRot(mode) ? amt % 16 : (amt > 16 ? 16 : amt);
        expEdges = (eff + 3) / 4 + 1;
        expOut   = refShift(x, amt, mode, dir);

        @(negedge CLK);
        ShifterIn = x;
        IRImm     = imm;
        AmtReg    = amtR;
        AmtSel    = sel;
        Mode      = mode;
        Dir       = dir;
        Start     = 1'b1;
        @(posedge CLK);
        #1;
        // Operands may change freely once accepted; poke keeps Start high while busy.
        Start     = poke;
        ShifterIn = 16'($urandom);
        IRImm     = 12'($urandom);
        AmtReg    = 16'($urandom);
        AmtSel    = 1'($urandom);
        Mode      = 2'($urandom);
        Dir       = 1'($urandom);
        check({tag, " busy"}, 32'(Busy), 32'd1);

        edges = 0;
        do begin
            @(posedge CLK);
            #1;
            edges++;
        end while (!Done && edges < 40);
        check({tag, " latency"}, 32'(edges), 32'(expEdges));
        check({tag, " result"}, 32'(ShifterOut), 32'(expOut));
        check({tag, " zext"}, 32'(ZeroExtOut), 32'({4'h0, imm}));
        check({tag, " sext"}, 32'(SignExtOut), 32'({{4{imm[11]}}, imm}));
        result = ShifterOut;

        Start = 1'b0;
        @(posedge CLK);
        #1;
        check({tag, " done pulse"}, 32'(Done), 32'd0);
        check({tag, " idle"}, 32'(Busy), 32'd0);
        check({tag, " hold"}, 32'(ShifterOut), 32'(expOut));
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] x;
        logic [11:0] imm;
        logic [15:0] amtR;
        int doneSeen;

        Rst       = 1'b1;
        Start     = 1'b1;
        ShifterIn = 16'h1234;
        IRImm     = 12'h801;
        AmtReg    = 16'd3;
        AmtSel    = 1'b0;
        Mode      = 2'b00;
        Dir       = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset busy", 32'(Busy), 32'd0);
        check("reset done", 32'(Done), 32'd0);
        check("reset out", 32'(ShifterOut), 32'd0);
        check("reset zext", 32'(ZeroExtOut), 32'd0);
        check("reset sext", 32'(SignExtOut), 32'd0);
        @(negedge CLK);
        Rst   = 1'b0;
        Start = 1'b0;

        runOp("lsr4", 16'hF00F, 12'h004, 16'h0000, 1'b0, 2'b00, 1'b1, 1'b0, res);
        check("lsr4 const", 32'(res), 32'h0F00);
        runOp("asr15", 16'h8000, 12'h00F, 16'h0000, 1'b0, 2'b01, 1'b1, 1'b0, res);
        check("asr15 const", 32'(res), 32'hFFFF);
        runOp("lsl20", 16'hFFFF, 12'h000, 16'd20, 1'b1, 2'b00, 1'b0, 1'b0, res);
        check("lsl20 const", 32'(res), 32'h0000);
        runOp("asr20", 16'h8001, 12'h000, 16'd20, 1'b1, 2'b01, 1'b1, 1'b0, res);
        check("asr20 const", 32'(res), 32'hFFFF);
        runOp("amt0", 16'hBEEF, 12'h800, 16'd0, 1'b1, 2'b00, 1'b0, 1'b0, res);
        check("amt0 const", 32'(res), 32'hBEEF);
        runOp("mode10", 16'h8001, 12'h000, 16'd17, 1'b1, 2'b10, 1'b0, 1'b0, res);
`ifdef ROTATE_EN
        check("rotate const", 32'(res), 32'h0003);
`else
        check("mode10 const", 32'(res), 32'h0000);
`endif
        runOp("poke", 16'h00F0, 12'h008, 16'd0, 1'b0, 2'b00, 1'b0, 1'b1, res);
        check("poke const", 32'(res), 32'hF000);

        for (int i = 0; i < 40; i++) begin
            x    = 16'($urandom);
            imm  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 20));
            amtR = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            runOp("rand", x, imm, amtR, 1'($urandom), 2'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), res);
        end

        // Reset mid-operation must discard the partial work.
        @(negedge CLK);
        ShifterIn = 16'h5A5A;
        IRImm     = 12'hABC;
        AmtReg    = 16'd16;
        AmtSel    = 1'b1;
        Mode      = 2'b00;
        Dir       = 1'b1;
        Start     = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        @(posedge CLK);
        #1;
        check("pre-reset busy", 32'(Busy), 32'd1);
        @(negedge CLK);
        Rst = 1'b1;
        @(posedge CLK);
        #1;
        check("midreset busy", 32'(Busy), 32'd0);
        check("midreset done", 32'(Done), 32'd0);
        check("midreset out", 32'(ShifterOut), 32'd0);
        check("midreset zext", 32'(ZeroExtOut), 32'd0);
        check("midreset sext", 32'(SignExtOut), 32'd0);
        @(negedge CLK);
        Rst      = 1'b0;
        doneSeen = 0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (Done || Busy) doneSeen++;
        end
        check("midreset no done", 32'(doneSeen), 32'd0);

        runOp("post-reset", 16'h0001, 12'h003, 16'd0, 1'b0, 2'b00, 1'b0, 1'b0, res);
        check("post-reset const", 32'(res), 32'h0008);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
